// File: rtl/head_shift_stream.sv
// Flow-controlled header shifter: drops a per-packet number of leading units and re-packs slices.
// Define HEAD_SHIFT_CHK_EN to enable protocol checking on o_err / o_err_cnt.
module head_shift_stream #(
    parameter int HEAD_W    = 256,
    parameter int UNIT_W    = 16,
    parameter int CANDI_NUM = 16,
    parameter int SHIFT_W   = $clog2(CANDI_NUM + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [HEAD_W-1:0]  i_head,
    input  logic               i_start,
    input  logic               i_tail,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [HEAD_W-1:0]  o_head,
    output logic               o_start,
    output logic               o_tail,
    output logic               o_err,
    output logic [15:0]        o_err_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [HEAD_W-1:0]  h_q, h_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               first_q, first_d;
    logic               out_valid_q, out_valid_d;
    logic [HEAD_W-1:0]  out_head_q, out_head_d;
    logic               out_start_q, out_start_d;
    logic               out_tail_q, out_tail_d;

    logic               out_free;
    logic               accept;
    logic               shift_over;
    logic [SHIFT_W-1:0] shift_clamp;
    logic [HEAD_W-1:0]  comb_next;
    logic [HEAD_W-1:0]  comb_data;

    assign out_free    = !out_valid_q || i_ready;
    assign accept      = i_valid && o_ready;
    assign shift_over  = i_shift > SHIFT_W'(CANDI_NUM);
    assign shift_clamp = shift_over ? SHIFT_W'(CANDI_NUM) : i_shift;

    always_comb begin
        unique case (state_q)
            S_IDLE:  o_ready = 1'b1;
            S_HOLD:  o_ready = out_free;
            default: o_ready = 1'b0;
        endcase
    end

    // In FLUSH the held slice is combined with an all-zero successor.
    always_comb begin
        comb_next = (state_q == S_FLUSH) ? '0 : i_head;
        comb_data = HEAD_W'(({h_q, comb_next} << (shift_q * UNIT_W)) >> HEAD_W);
    end

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        shift_d     = shift_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;
        out_head_d  = out_head_q;
        out_start_d = out_start_q;
        out_tail_d  = out_tail_q;

        if (out_free) out_valid_d = 1'b0;

        // A start slice always opens a new packet; any partially held packet is abandoned.
        if (accept && i_start) begin
            h_d     = i_head;
            shift_d = shift_clamp;
            first_d = 1'b1;
            state_d = i_tail ? S_FLUSH : S_HOLD;
        end else if (accept && state_q == S_HOLD) begin
            out_valid_d = 1'b1;
            out_head_d  = comb_data;
            out_start_d = first_q;
            out_tail_d  = 1'b0;
            first_d     = 1'b0;
            h_d         = i_head;
            if (i_tail) state_d = S_FLUSH;
        end

        if (state_q == S_FLUSH && out_free) begin
            out_valid_d = 1'b1;
            out_head_d  = comb_data;
            out_start_d = first_q;
            out_tail_d  = 1'b1;
            state_d     = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            h_q         <= '0;
            shift_q     <= '0;
            first_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_head_q  <= '0;
            out_start_q <= 1'b0;
            out_tail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            shift_q     <= shift_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_head_q  <= out_head_d;
            out_start_q <= out_start_d;
            out_tail_q  <= out_tail_d;
        end
    end

    assign o_valid = out_valid_q;
    assign o_head  = out_head_q;
    assign o_start = out_start_q;
    assign o_tail  = out_tail_q;

`ifdef HEAD_SHIFT_CHK_EN
    logic        err_event;
    logic        err_q;
    logic [15:0] err_cnt_q;

    // Simultaneous violations on one slice count as a single event.
    assign err_event = accept && ((state_q == S_IDLE && !i_start) ||
                                  (state_q == S_HOLD && i_start) ||
                                  (i_start && shift_over));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= err_event;
            if (err_event && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign o_err     = err_q;
    assign o_err_cnt = err_cnt_q;
`else
    assign o_err     = 1'b0;
    assign o_err_cnt = '0;
`endif

endmodule
